fb_uart_loader: RTL and testbench
=================================

// Module: fb_uart_loader
// PURPOSE
//  Upstream writer for the framebuffer's write port (port A, 8-bit x 4096). Consumes bytes from the
//  UART receiver, decodes a small command protocol, and issues single-cycle byte writes so that a host
//  can stream whole frames, poke single bytes or clear the buffer. Runs on the root clock and sits
//  beside the scan-side read path, which uses port B.
// PARAMETERS
//  ADDR_WIDTH      12         framebuffer byte-address width (4096 bytes = 2048 RGB565 pixels)
//  TIMEOUT_WIDTH   16         width of the inter-byte timeout counter
//  TIMEOUT_CYCLES  16'd53200  idle clk_in cycles allowed between payload bytes (1 ms @ 53.2 MHz)
//  CMD_FRAME       8'h46      'F': next 2^ADDR_WIDTH bytes fill addresses 0..4095 in order
//  CMD_POKE        8'h50      'P': addr_hi, addr_lo, data -> one byte write
//  CMD_CLEAR       8'h43      'C': autonomous write of 8'h00 to every address
// PORTS
//  clk_in        in   1   root clock
//  reset         in   1   asynchronous, active-low reset
//  rx_data       in   8   received byte, valid only while rx_valid is high
//  rx_valid      in   1   single-cycle strobe, one per received byte
//  fb_addr       out  12  framebuffer port A address
//  fb_data       out  8   framebuffer port A write data
//  fb_wr         out  1   port A write enable; 1-cycle pulse, high for exactly one write
//  fb_clk_en     out  1   port A clock enable; equals fb_wr
//  busy          out  1   high in every state except IDLE
//  done          out  1   1-cycle pulse when a FRAME, POKE or CLEAR completes normally
//  error         out  1   1-cycle pulse on timeout abort or on a byte dropped during CLEAR
// BEHAVIOUR
//  - Reset (reset=0, any time): all outputs go to 0, state goes to IDLE, counters are cleared, and any
//    partial command is discarded. No write is issued on the cycle that reset deasserts.
//  - States: IDLE, FRAME, POKE_AH, POKE_AL, POKE_D, CLEAR.
//  - IDLE: on rx_valid, 'F' -> FRAME with byte_cnt=0; 'P' -> POKE_AH; 'C' -> CLEAR with byte_cnt=0.
//    Any other byte is ignored silently, with no error.
//  - FRAME: each rx_valid writes rx_data to address byte_cnt, then byte_cnt increments. After the write
//    to 4095: done pulses and the state returns to IDLE. Byte order is pixel LSB at even address, MSB
//    at odd address.
//  - POKE_AH latches rx_data[ADDR_WIDTH-9:0] as the high address bits; upper bits are ignored.
//    POKE_AL latches the low 8 address bits. POKE_D writes rx_data to the latched address, pulses done,
//    and returns to IDLE.
//  - CLEAR: one write of 8'h00 per cycle to byte_cnt = 0..4095, which takes 4096 cycles. done pulses in
//    the cycle after the last write. Any rx_valid during CLEAR drops the byte and pulses error; CLEAR
//    continues.
//  - Write latency: fb_wr/fb_addr/fb_data are registered and asserted the cycle after the rx_valid that
//    caused them. For FRAME/POKE_D, done is high in the same cycle as the final fb_wr.
//  - Timeout: the counter clears on every rx_valid and on entry to any payload state. It increments in
//    FRAME, POKE_AH, POKE_AL and POKE_D. At TIMEOUT_CYCLES the state returns to IDLE, error pulses, and
//    no write is issued. If rx_valid coincides with expiry, the byte wins: it is processed and the
//    counter clears. The timeout is inactive in IDLE and CLEAR.
//  - Address wrap: byte_cnt is ADDR_WIDTH+1 bits wide; terminal detection uses byte_cnt==2^ADDR_WIDTH-1.
//    fb_addr never wraps to 0 within one command.
//  - Back-to-back commands: a command byte arriving in the cycle after done is accepted normally.
// STRUCTURE
//  - Shared package led_matrix_pkg: CMD_* byte constants, FB_ADDR_WIDTH, FB_BYTES, and the state enum
//    fb_loader_state_t.
//  - One sub-module: fb_byte_timeout (load/clear, enable, expiry pulse), with TIMEOUT_WIDTH and
//    TIMEOUT_CYCLES passed as parameters.
//  - The FSM and the write-output registers stay in this module.
// TESTING
//  1 Reset: drive reset=0 mid-FRAME at byte 100 -> all outputs 0 immediately. After release, 'P',00,05,AA
//    -> a single write of addr 0x005 with data 0xAA.
//  2 Poke: 'P',0x1F,0xFF,0x3C -> exactly one fb_wr, fb_addr=0xFFF, fb_data=0x3C. done pulses with fb_wr.
//  3 Frame: 'F' then 4096 bytes of value i[7:0] -> 4096 writes at addr=i with data=i[7:0]. done on the
//    last write; busy low the next cycle.
//  4 Timeout: 'F' + 10 bytes, then idle for TIMEOUT_CYCLES -> error pulse, return to IDLE, 10 writes
//    total. Then 'P',0,0,0x55 works.
//  5 Clear with collision: 'C', then rx_valid 0x41 at cycle 200 -> 4096 zero writes, one error pulse,
//    done after addr 0xFFF.
//  6 Junk and edge: bytes 0x00,0xFF,'x' in IDLE -> no write, no error. rx_valid on the expiry cycle of
//    POKE_AL -> byte accepted, no error.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED-matrix framebuffer loader: command bytes,
// framebuffer geometry and the loader state encoding.
package led_matrix_pkg;

   localparam int FB_ADDR_WIDTH = 12;
   localparam int FB_BYTES      = 4096;

   localparam logic [7:0] CMD_FRAME = 8'h46;  // 'F'
   localparam logic [7:0] CMD_POKE  = 8'h50;  // 'P'
   localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FRAME   = 3'd1,
      ST_POKE_AH = 3'd2,
      ST_POKE_AL = 3'd3,
      ST_POKE_D  = 3'd4,
      ST_CLEAR   = 3'd5
   } fb_loader_state_t;

endpackage

// File: rtl/fb_byte_timeout.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and
// flags the cycle in which the idle time reaches TIMEOUT_CYCLES. A clear in
// the same cycle suppresses the expiry, so an arriving byte always wins.
module fb_byte_timeout #(
   parameter int                       TIMEOUT_WIDTH  = 16,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'd53200
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

   logic [TIMEOUT_WIDTH-1:0] count_r;

   // Idle counter: held at zero while disabled or cleared, else counts up.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clr || !en) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + TIMEOUT_WIDTH'(1);
      end
   end

   // Expiry strobe for the cycle that completes the allowed idle time.
   always_comb begin
      if (en && !clr && (count_r == LAST_COUNT)) begin
         expired = 1'b1;
      end else begin
         expired = 1'b0;
      end
   end

endmodule

// File: rtl/fb_uart_loader.sv
// UART command decoder that drives the framebuffer write port. Supports
// full-frame streaming ('F'), single-byte poke ('P') and autonomous clear
// ('C'). All port-A signals and status pulses are registered.
module fb_uart_loader
   import led_matrix_pkg::*;
#(
   parameter int                       ADDR_WIDTH     = FB_ADDR_WIDTH,
   parameter int                       TIMEOUT_WIDTH  = 16,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'd53200,
   parameter logic [7:0]               CMD_FRAME_B    = CMD_FRAME,
   parameter logic [7:0]               CMD_POKE_B     = CMD_POKE,
   parameter logic [7:0]               CMD_CLEAR_B    = CMD_CLEAR
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [7:0]            fb_data,
   output logic                  fb_wr,
   output logic                  fb_clk_en,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   // byte_cnt carries one extra bit so CLEAR can spend a final cycle at
   // 2^ADDR_WIDTH to emit done without wrapping the address.
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);
   localparam logic [ADDR_WIDTH:0] END_CNT   = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

   fb_loader_state_t        state_r, state_next_s;
   logic [ADDR_WIDTH:0]     byte_cnt_r, byte_cnt_next_s;
   logic [ADDR_WIDTH-1:0]   poke_addr_r, poke_addr_next_s;
   logic [ADDR_WIDTH-1:0]   fb_addr_r, fb_addr_s;
   logic [7:0]              fb_data_r, fb_data_s;
   logic                    fb_wr_r, fb_wr_s;
   logic                    done_r, done_s;
   logic                    error_r, error_s;
   logic                    busy_r;
   logic                    tmo_en_s;
   logic                    tmo_expired_s;

   assign tmo_en_s = (state_r == ST_FRAME)   || (state_r == ST_POKE_AH) ||
                     (state_r == ST_POKE_AL) || (state_r == ST_POKE_D);

   fb_byte_timeout #(
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in  (clk_in),
      .reset   (reset),
      .clr     (rx_valid),
      .en      (tmo_en_s),
      .expired (tmo_expired_s)
   );

   // State register.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode: command dispatch, payload sequencing, timeout abort.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  CMD_FRAME_B: state_next_s = ST_FRAME;
                  CMD_POKE_B:  state_next_s = ST_POKE_AH;
                  CMD_CLEAR_B: state_next_s = ST_CLEAR;
                  default:     state_next_s = ST_IDLE;
               endcase
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FRAME: begin
            if (rx_valid) begin
               state_next_s = (byte_cnt_r == LAST_ADDR) ? ST_IDLE : ST_FRAME;
            end else if (tmo_expired_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_FRAME;
            end
         end
         ST_POKE_AH: begin
            if (rx_valid) begin
               state_next_s = ST_POKE_AL;
            end else if (tmo_expired_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_POKE_AH;
            end
         end
         ST_POKE_AL: begin
            if (rx_valid) begin
               state_next_s = ST_POKE_D;
            end else if (tmo_expired_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_POKE_AL;
            end
         end
         ST_POKE_D: begin
            if (rx_valid || tmo_expired_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_POKE_D;
            end
         end
         ST_CLEAR: begin
            if (byte_cnt_r == END_CNT) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CLEAR;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode: next values of the write port, status pulses and counters.
   always_comb begin
      fb_wr_s          = 1'b0;
      fb_addr_s        = fb_addr_r;
      fb_data_s        = fb_data_r;
      done_s           = 1'b0;
      error_s          = 1'b0;
      byte_cnt_next_s  = byte_cnt_r;
      poke_addr_next_s = poke_addr_r;
      case (state_r)
         ST_IDLE: begin
            if (rx_valid) begin
               byte_cnt_next_s = '0;
            end else begin
               byte_cnt_next_s = byte_cnt_r;
            end
         end
         ST_FRAME: begin
            if (rx_valid) begin
               fb_wr_s         = 1'b1;
               fb_addr_s       = byte_cnt_r[ADDR_WIDTH-1:0];
               fb_data_s       = rx_data;
               done_s          = (byte_cnt_r == LAST_ADDR);
               byte_cnt_next_s = byte_cnt_r + (ADDR_WIDTH+1)'(1);
            end else begin
               error_s = tmo_expired_s;
            end
         end
         ST_POKE_AH: begin
            if (rx_valid) begin
               poke_addr_next_s = {rx_data[ADDR_WIDTH-9:0], poke_addr_r[7:0]};
            end else begin
               error_s = tmo_expired_s;
            end
         end
         ST_POKE_AL: begin
            if (rx_valid) begin
               poke_addr_next_s = {poke_addr_r[ADDR_WIDTH-1:8], rx_data};
            end else begin
               error_s = tmo_expired_s;
            end
         end
         ST_POKE_D: begin
            if (rx_valid) begin
               fb_wr_s   = 1'b1;
               fb_addr_s = poke_addr_r;
               fb_data_s = rx_data;
               done_s    = 1'b1;
            end else begin
               error_s = tmo_expired_s;
            end
         end
         ST_CLEAR: begin
            // Bytes arriving during a clear are dropped and flagged.
            error_s = rx_valid;
            if (byte_cnt_r == END_CNT) begin
               done_s = 1'b1;
            end else begin
               fb_wr_s         = 1'b1;
               fb_addr_s       = byte_cnt_r[ADDR_WIDTH-1:0];
               fb_data_s       = 8'h00;
               byte_cnt_next_s = byte_cnt_r + (ADDR_WIDTH+1)'(1);
            end
         end
         default: begin
            byte_cnt_next_s = '0;
         end
      endcase
   end

   // Registered write port, status pulses, byte counter and poke address.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         fb_wr_r     <= 1'b0;
         fb_addr_r   <= '0;
         fb_data_r   <= 8'h00;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         busy_r      <= 1'b0;
         byte_cnt_r  <= '0;
         poke_addr_r <= '0;
      end else begin
         fb_wr_r     <= fb_wr_s;
         fb_addr_r   <= fb_addr_s;
         fb_data_r   <= fb_data_s;
         done_r      <= done_s;
         error_r     <= error_s;
         busy_r      <= (state_next_s != ST_IDLE);
         byte_cnt_r  <= byte_cnt_next_s;
         poke_addr_r <= poke_addr_next_s;
      end
   end

   assign fb_addr   = fb_addr_r;
   assign fb_data   = fb_data_r;
   assign fb_wr     = fb_wr_r;
   assign fb_clk_en = fb_wr_r;
   assign done      = done_r;
   assign error     = error_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_fb_uart_loader.sv
// Directed bench for fb_uart_loader with a write scoreboard. Expected
// writes are queued as bytes are driven and popped by a write monitor.
module tb_fb_uart_loader;

   localparam int                TO     = 200;
   localparam logic [15:0]       TO_CYC = 16'd200;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
      logic        done;
   } wr_t;

   logic        clk_in;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [11:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_wr;
   logic        fb_clk_en;
   logic        busy;
   logic        done;
   logic        error;

   int checks    = 0;
   int failures  = 0;
   int wr_cnt    = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;
   wr_t exp_q[$];

   fb_uart_loader #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .fb_addr   (fb_addr),
      .fb_data   (fb_data),
      .fb_wr     (fb_wr),
      .fb_clk_en (fb_clk_en),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_in);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk_in);
      rx_valid = 1'b0;
   endtask

   task automatic push(input logic [11:0] a, input logic [7:0] d, input logic dn);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.done = dn;
      exp_q.push_back(w);
   endtask

   task automatic settle();
      @(negedge clk_in);
      #1;
   endtask

   // Write monitor: every fb_wr must match the head of the scoreboard.
   always @(negedge clk_in) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (fb_wr) begin
         wr_t w;
         wr_cnt++;
         check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(w.addr));
            check("wr_data", 32'(fb_data), 32'(w.data));
            check("wr_done", 32'(done), 32'(w.done));
            check("wr_clk_en", 32'(fb_clk_en), 32'd1);
         end
      end else if (fb_clk_en !== 1'b0) begin
         check("idle_clk_en", 32'(fb_clk_en), 32'd0);
      end
   end

   // Global time bound.
   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0, w0, d0;
      bit got;
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk_in);
      check("reset_outs", 32'({fb_wr, fb_clk_en, busy, done, error, fb_addr, fb_data}), 32'd0);
      reset = 1'b1;

      // 1: reset in the middle of a frame, then a poke
      send(8'h46);
      for (int i = 0; i < 100; i++) begin
         push(12'(i), 8'(i), 1'b0);
         send(8'(i));
      end
      @(posedge clk_in);
      #2 reset = 1'b0;
      #1;
      check("t1_async_reset", 32'({fb_wr, fb_clk_en, busy, done, error, fb_addr, fb_data}), 32'd0);
      check("t1_writes", 32'(wr_cnt), 32'd100);
      @(negedge clk_in);
      reset = 1'b1;
      push(12'h005, 8'hAA, 1'b1);
      send(8'h50); send(8'h00); send(8'h05); send(8'hAA);
      settle();
      check("t1_poke_writes", 32'(wr_cnt), 32'd101);
      check("t1_poke_done", 32'(done_cnt), 32'd1);

      // 2: poke to the top address, high address bits masked
      push(12'hFFF, 8'h3C, 1'b1);
      send(8'h50); send(8'h1F); send(8'hFF); send(8'h3C);
      settle();
      check("t2_writes", 32'(wr_cnt), 32'd102);
      check("t2_done", 32'(done_cnt), 32'd2);
      check("t2_busy", 32'(busy), 32'd0);

      // 3: full frame
      send(8'h46);
      for (int i = 0; i < 4096; i++) begin
         push(12'(i), 8'(i), (i == 4095));
         send(8'(i));
      end
      settle();
      check("t3_busy_after", 32'(busy), 32'd0);
      check("t3_writes", 32'(wr_cnt), 32'd4198);
      check("t3_done", 32'(done_cnt), 32'd3);
      check("t3_no_error", 32'(err_cnt), 32'd0);

      // 4: inter-byte timeout during a frame
      e0 = err_cnt; w0 = wr_cnt;
      send(8'h46);
      for (int i = 0; i < 10; i++) begin
         push(12'(i), 8'(8'hA0 + i), 1'b0);
         send(8'(8'hA0 + i));
      end
      repeat (TO - 5) @(negedge clk_in);
      #1;
      check("t4_no_early_error", 32'(err_cnt), 32'(e0));
      check("t4_busy_waiting", 32'(busy), 32'd1);
      repeat (10) @(negedge clk_in);
      #1;
      check("t4_error", 32'(err_cnt), 32'(e0 + 1));
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_writes", 32'(wr_cnt), 32'(w0 + 10));
      push(12'h000, 8'h55, 1'b1);
      send(8'h50); send(8'h00); send(8'h00); send(8'h55);
      settle();
      check("t4_poke_done", 32'(done_cnt), 32'd4);
      check("t4_poke_writes", 32'(wr_cnt), 32'(w0 + 11));

      // 5: clear with a colliding byte
      e0 = err_cnt; w0 = wr_cnt; d0 = done_cnt;
      for (int i = 0; i < 4096; i++) push(12'(i), 8'h00, 1'b0);
      send(8'h43);
      repeat (198) @(negedge clk_in);
      send(8'h41);
      got = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk_in);
         #1;
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      check("t5_done_seen", 32'(got), 32'd1);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t5_writes", 32'(wr_cnt), 32'(w0 + 4096));
      check("t5_error", 32'(err_cnt), 32'(e0 + 1));
      settle();
      check("t5_idle", 32'(busy), 32'd0);

      // 6: junk in IDLE, then a byte landing on the timeout expiry cycle
      e0 = err_cnt; w0 = wr_cnt; d0 = done_cnt;
      send(8'h00); send(8'hFF); send(8'h78);
      repeat (5) settle();
      check("t6_junk_writes", 32'(wr_cnt), 32'(w0));
      check("t6_junk_error", 32'(err_cnt), 32'(e0));
      check("t6_junk_busy", 32'(busy), 32'd0);
      push(12'h123, 8'h77, 1'b1);
      send(8'h50);
      send(8'h01);
      repeat (TO - 2) @(negedge clk_in);
      send(8'h23);
      send(8'h77);
      settle();
      check("t6_edge_error", 32'(err_cnt), 32'(e0));
      check("t6_edge_writes", 32'(wr_cnt), 32'(w0 + 1));
      check("t6_edge_done", 32'(done_cnt), 32'(d0 + 1));
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
